// File: rtl/noise_lfsr_checker_if.sv
// noise_lfsr_checker_if: noise word stream in, lock/error status out
interface noise_lfsr_checker_if #(
    parameter int ERRCNT_W = 16
);
    logic                din_valid;
    logic [7:0]          din;
    logic                clr_cnt;
    logic                locked;
    logic                err;
    logic [ERRCNT_W-1:0] err_count;
    logic [1:0]          state;
    modport master (output din_valid, din, clr_cnt, input locked, err, err_count, state);
    modport slave (input din_valid, din, clr_cnt, output locked, err, err_count, state);
endinterface

// File: rtl/noise_lfsr_checker.sv
// noise_lfsr_checker: self-syncing checker for the 23-bit noise generator; NOISE_CHK_RESYNC_EN enables re-seed after LOSS_THRESH misses
module noise_lfsr_checker #(
    parameter int LOSS_THRESH = 4,
    parameter int ERRCNT_W = 16
) (
    input logic clk,
    input logic rst,
    noise_lfsr_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SEED = 2'd1, LOCKED = 2'd2} state_t;

    if (LOSS_THRESH < 1 || LOSS_THRESH > 15) begin : g_bad_thresh
        $error("LOSS_THRESH must be in 1..15");
    end

    function automatic logic [22:0] step(input logic [22:0] x);
        return (x == 23'd0) ? 23'h37242B : {x[21:0], x[22] ^ x[17]};
    endfunction

    function automatic logic [7:0] taps(input logic [22:0] x);
        return {x[22], x[20], x[16], x[13], x[11], x[7], x[4], x[2]};
    endfunction

    state_t              st, st_nxt;
    logic [22:0]         s, s_nxt, p, shifted;
    logic [4:0]          seed_cnt, seed_nxt;
    logic [ERRCNT_W-1:0] cnt, cnt_nxt;
    logic                locked, err, err_nxt, mis, lost, last_seed, take;

    assign p         = step(s);
    assign mis       = taps(p) != bus.din;
    assign shifted   = {s[21:0], bus.din[0]};
    assign last_seed = seed_cnt == 5'd22;
    assign take      = bus.din_valid && st == LOCKED;

`ifdef NOISE_CHK_RESYNC_EN
    logic [3:0] miss, miss_nxt;
    assign lost     = take && mis && miss == 4'(LOSS_THRESH - 1);
    assign miss_nxt = take ? ((mis && !lost) ? miss + 4'd1 : 4'd0) : miss;
    // Length of the current run of consecutive mismatches while locked
    always_ff @(posedge clk or negedge rst)
        if (!rst) miss <= 4'd0;
        else miss <= miss_nxt;
`else
    assign lost = 1'b0;
`endif

    // Next state: seed by shifting g2 in, then predict and compare each word
    always_comb begin
        st_nxt   = st;
        s_nxt    = s;
        seed_nxt = seed_cnt;
        err_nxt  = 1'b0;
        if (bus.din_valid) begin
            if (st == LOCKED) begin
                s_nxt    = p;
                err_nxt  = mis;
                st_nxt   = lost ? SEED : LOCKED;
                seed_nxt = 5'd0;
            end else begin
                // 23 seed bits reconstruct the state two steps back; catch up by two
                s_nxt    = last_seed ? step(step(shifted)) : shifted;
                seed_nxt = last_seed ? 5'd0 : seed_cnt + 5'd1;
                st_nxt   = last_seed ? LOCKED : SEED;
            end
        end
        cnt_nxt = bus.clr_cnt ? '0 : (err_nxt && !(&cnt)) ? cnt + 1'b1 : cnt;
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            st       <= IDLE;
            s        <= 23'd0;
            seed_cnt <= 5'd0;
            cnt      <= '0;
            err      <= 1'b0;
            locked   <= 1'b0;
        end else begin
            st       <= st_nxt;
            s        <= s_nxt;
            seed_cnt <= seed_nxt;
            cnt      <= cnt_nxt;
            err      <= err_nxt;
            locked   <= st_nxt == LOCKED;
        end

    assign bus.state     = st;
    assign bus.locked    = locked;
    assign bus.err       = err;
    assign bus.err_count = cnt;
endmodule

// File: tb/tb_noise_lfsr_checker.sv
// tb_noise_lfsr_checker: scoreboard bench driving a model noise generator into the checker
module tb_noise_lfsr_checker;
    localparam int CW = 4;
    localparam int LOSS = 4;
    localparam int MAXC = (1 << CW) - 1;

    typedef struct packed {
        logic       l;
        logic       e;
        logic [3:0] c;
        logic [1:0] s;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    noise_lfsr_checker_if #(.ERRCNT_W(CW)) bus ();
    noise_lfsr_checker #(.LOSS_THRESH(LOSS), .ERRCNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;
    exp_t q[$];
    logic [22:0] g;
    int ph, seeded, run, errc;

    function automatic logic [22:0] gstep(input logic [22:0] x);
        return (x == 23'd0) ? 23'h37242B : {x[21:0], x[22] ^ x[17]};
    endfunction

    function automatic logic [7:0] gword(input logic [22:0] x);
        return {x[22], x[20], x[16], x[13], x[11], x[7], x[4], x[2]};
    endfunction

    function automatic logic [7:0] rmask();
        return 8'($urandom_range(1, 255));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " locked"}, 32'(bus.locked), 32'd0);
        chk({tag, " err"}, 32'(bus.err), 32'd0);
        chk({tag, " err_count"}, 32'(bus.err_count), 32'd0);
        chk({tag, " state"}, 32'(bus.state), 32'd0);
    endtask

    // One clock of stimulus; mask corrupts the true word, only honoured once locked
    task automatic cycle(input logic v, input logic [7:0] mask, input logic clr);
        exp_t x;
        logic [7:0] m;
        logic e;
        @(negedge clk);
        e = 1'b0;
        m = (ph == 2) ? mask : 8'h00;
        bus.din_valid = v;
        bus.clr_cnt = clr;
        bus.din = v ? (gword(g) ^ m) : 8'($urandom);
        if (v) begin
            g = gstep(g);
            if (ph == 2) begin
                e = m != 8'h00;
                if (e) begin
                    errc = (errc == MAXC) ? MAXC : errc + 1;
                    run++;
`ifdef NOISE_CHK_RESYNC_EN
                    if (run == LOSS) begin
                        ph = 1;
                        run = 0;
                        seeded = 0;
                    end
`endif
                end else run = 0;
            end else begin
                seeded++;
                if (seeded == 23) begin
                    ph = 2;
                    seeded = 0;
                end else ph = 1;
            end
        end
        if (clr) errc = 0;
        x.l = ph == 2;
        x.e = e;
        x.c = 4'(errc);
        x.s = 2'(ph);
        q.push_back(x);
    endtask

    task automatic gap_word(input logic [7:0] mask, input logic clr);
        repeat ($urandom_range(0, 3)) cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, mask, clr);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        #1 chk_zero("async rst");
        ph = 0;
        seeded = 0;
        run = 0;
        errc = 0;
        bus.din_valid = 1'b0;
        bus.clr_cnt = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("rst held");
        rst = 1'b1;
    endtask

    // Monitor: compare every registered output against the queued expectation
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("locked", 32'(bus.locked), 32'(x.l));
                chk("err", 32'(bus.err), 32'(x.e));
                chk("err_count", 32'(bus.err_count), 32'(x.c));
                chk("state", 32'(bus.state), 32'(x.s));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus.din_valid = 1'b0;
        bus.din = 8'h00;
        bus.clr_cnt = 1'b0;
        g = 23'h37242B;
        ph = 0;
        seeded = 0;
        run = 0;
        errc = 0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
        repeat (23) cycle(1'b1, 8'h00, 1'b0);
        repeat (1000) cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b1, 8'h08, 1'b0);
        repeat (50) cycle(1'b1, 8'h00, 1'b0);
        repeat (200) gap_word(($urandom_range(0, 7) == 0) ? rmask() : 8'h00, $urandom_range(0, 15) == 0);
        while (ph != 2) cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b1, 8'h00, 1'b1);
`ifdef NOISE_CHK_RESYNC_EN
        repeat (LOSS) cycle(1'b1, rmask(), 1'b0);
        repeat (23) gap_word(8'h00, 1'b0);
`else
        repeat (20) cycle(1'b1, rmask(), 1'b0);
`endif
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b1, rmask(), 1'b1);
        cycle(1'b1, 8'h00, 1'b0);
        do_reset();
        repeat (23) gap_word(8'h00, 1'b0);
        repeat (100) gap_word(($urandom_range(0, 9) == 0) ? rmask() : 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        chk("queue drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/noise_lfsr_checker.md
# noise_lfsr_checker

Receive-side checker for the 23-bit SID-style noise generator used by the audio block. It consumes the generator's 8-bit tapped noise word, self-synchronises a local shadow copy of the generator state, predicts every following word, and counts mismatches. It sits on the audio noise path as a bring-up and verification monitor: it can be tapped in RTL sims or on the badge to prove the noise source is intact.

## Interface
- `LOSS_THRESH`, default 4: consecutive mismatched words in LOCKED that force loss of lock (range 1–15).
- `ERRCNT_W`, default 16: width of the error counter.

Ports, clock and reset first:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-low.
- `din_valid`  in  1  `din` carries one new generator word; exactly one generator step per valid word.
- `din`  in  8  generator output word, `{g22,g20,g16,g13,g11,g7,g4,g2}` of generator state g.
- `clr_cnt`  in  1  synchronous clear of `err_count`.
- `locked`  out  1  shadow state is synchronised.
- `err`  out  1  one-cycle pulse: previous valid word mismatched while LOCKED.
- `err_count`  out  ERRCNT_W  saturating mismatch count.
- `state`  out  2  FSM state: 0 IDLE, 1 SEED, 2 LOCKED.

## Operation
- Shadow register S is 23 bits. step(x) = `{x[21:0], x[22]^x[17]}`; if x==0, step(x) = `23'h37242B`, mirroring the generator's zero reload.
- taps(x) = `{x[22],x[20],x[16],x[13],x[11],x[7],x[4],x[2]}`.
- IDLE: entered on reset. First `din_valid` → SEED, that word counted as seed word 1.
- SEED: each valid word shifts `din[0]` in: S ← `{S[21:0], din[0]}`. A 5-bit seed counter counts words.
  - After the 23rd word, S equals the generator state two steps earlier. On that word, load S ← step(step(`{S[21:0],din[0]}`)) and go to LOCKED.
  - No comparisons in SEED; `err` stays 0.
- LOCKED: each valid word: P = step(S); mismatch = (taps(P) != din); S ← P. S advances on every valid word, match or not.
  - Mismatch: `err` pulses; `err_count` increments, saturating at all-ones; miss counter increments.
  - Match: miss counter clears.
  - Miss counter reaching `LOSS_THRESH`: see Configuration.
- `clr_cnt` zeroes `err_count` and wins over a same-cycle increment. It has no effect on FSM, S or miss counter.
- `din_valid`=0: no state change. `err` returns to 0.

## Timing
- All outputs are registered.
- Reset values: `locked`=0, `err`=0, `err_count`=0, `state`=0, S=0, seed and miss counters 0. Reset is asynchronous and takes effect mid-operation without waiting for `clk`.
- `locked` rises the cycle after the 23rd seed word is accepted. The 24th valid word is the first one compared.
- `err` is high for exactly the one cycle after the clock edge that accepted the mismatched word. `err_count` updates on the same edge.
- Lock loss: `locked` falls the cycle after the `LOSS_THRESH`-th consecutive mismatch. The next valid word is seed word 1.
- Sustained throughput: one word per clock. There is no backpressure.

## Configuration
- `NOISE_CHK_RESYNC_EN` defined: reaching `LOSS_THRESH` consecutive misses → SEED, with seed and miss counters cleared and `locked` dropped. `err_count` is retained.
- Macro undefined: the miss counter and resync logic are removed. The checker stays LOCKED until reset, counting every mismatch.

## Test plan
- Feed the generator sequence from reset state `23'h37242B`, one word per clock → `locked`=1 the cycle after word 23. Continue for 1000 words → `err` never asserts and `err_count`=0.
- After lock, flip `din[3]` on one word → `err` is high for exactly one cycle, `err_count`=1, `locked` stays 1, and the following correct words give no further errors.
- With `NOISE_CHK_RESYNC_EN`: 4 consecutive corrupted words → `err_count`=4 and `locked` drops after word 4, `state`=SEED. The next 23 good words re-lock with `err_count` still 4.
- Randomly drop `din_valid` for 0–3 cycles between words, both during seeding and after lock → lock timing is counted in valid words only, and no errors occur.
- `ERRCNT_W`=4, macro undefined: 20 mismatches → `err_count`=15. Assert `clr_cnt` in the same cycle as a mismatch → `err_count`=0 next cycle, while `err` still pulses.
- Assert `rst` low asynchronously mid-lock, between clock edges → all outputs are 0 immediately. After release, the checker re-seeds from the next valid word.
